// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU sharing arbiter.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    MUL = 4'b0010,
    SLL = 4'b0100,
    SRL = 4'b0101,
    SRA = 4'b0110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int unsigned ALU_W = 32;

  // True for op codes the ALU implements; anything else completes with an error flag.
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ADD, SUB, MUL, SLL, SRL, SRA: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ALU_Base.sv
// Single-cycle combinational 32-bit ALU shared by all requesters.
module ALU_Base
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  Ctr,
  output logic [31:0] Out
);

  // Operation select; the low 32 bits of a signed product equal those of the unsigned product.
  always_comb begin
    Out = '0;
    case (Ctr)
      ADD:     Out = A + B;
      SUB:     Out = A - B;
      MUL:     Out = A * B;
      SLL:     Out = A << B[4:0];
      SRL:     Out = A >> B[4:0];
      SRA:     Out = $unsigned($signed(A) >>> B[4:0]);
      default: Out = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after ptr_i, wrapping around.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned cand;

  // Scan ptr_i+1 .. ptr_i+N modulo N; the first asserted request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[IDX_W'(cand)]) begin
        any_o                = 1'b1;
        gnt_o[IDX_W'(cand)]  = 1'b1;
        idx_o                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU_Base between NUM_REQ requesters with round-robin arbitration.
// Operands and result are registered so the ALU sits between flops.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned OP_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [31:0]        alu_out;
  logic               op_legal;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  ALU_Base u_alu (
    .A   (32'(a_q)),
    .B   (32'(b_q)),
    .Ctr (4'(op_q)),
    .Out (alu_out)
  );

  assign op_legal = is_legal_op(4'(op_q)) && ((op_q >> 4) == '0);

  // State, pointer, operand and result registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      owner_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, capture result in EXEC, wait for handshake in RESP.
  // req_ready is gated by rst_n so it drops the moment reset is asserted.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any && rst_n) begin
          req_ready = gnt;
          op_d      = req_op[32'(gnt_idx) * OP_W +: OP_W];
          a_d       = req_a[32'(gnt_idx) * WIDTH +: WIDTH];
          b_d       = req_b[32'(gnt_idx) * WIDTH +: WIDTH];
          owner_d   = gnt_idx;
          rr_ptr_d  = gnt_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        data_d  = op_legal ? WIDTH'(alu_out) : '0;
        err_d   = !op_legal;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response valid is one-hot on the owner while in RESP.
  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign rsp_data = data_q;
  assign rsp_err  = err_q;
  assign busy     = (state_q != IDLE);

endmodule
